// File: rtl/isqrt_pkg.sv
// Shared definitions for the iterative integer square-root unit and its helpers.
package isqrt_pkg;

   localparam int ISQRT_N = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration: brings down two radicand
// bits, tries to append a 1 to the root, and keeps it only if the remainder allows.
module isqrt_step
   import isqrt_pkg::*;
#(
   parameter int N = ISQRT_N
) (
   input  logic [N+1:0] rem,
   input  logic [N-1:0] root,
   input  logic [1:0]   digit,
   output logic [N+1:0] rem_next,
   output logic [N-1:0] root_next
);

   logic [N+1:0] rem_shift;
   logic [N+1:0] trial;

   // NOTE: every output of a combinational block gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      rem_shift = (rem << 2) | {{N{1'b0}}, digit};
      trial     = {root, 2'b01};
      rem_next  = rem_shift;
      root_next = root << 1;
      if (rem_shift >= trial) begin
         rem_next  = rem_shift - trial;
         root_next = (root << 1) | {{(N-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Sequential y = floor(sqrt(x)): one result bit per clock, one request in flight,
// and a new request may be taken in the same cycle a result is presented.
module isqrt_iter_fsm
   import isqrt_pkg::*;
#(
   parameter int N = ISQRT_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           x_vld,
   input  logic [2*N-1:0] x,
   output logic           y_vld,
   output logic [N-1:0]   y,
   output logic           busy,
   output logic           err
);

   localparam int CNT_W = $clog2(N);

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic [CNT_W-1:0] cnt;
   logic [2*N-1:0]   xs;
   logic [N+1:0]     rem;
   logic [N-1:0]     root;
   logic [N+1:0]     rem_next;
   logic [N-1:0]     root_next;
   logic             last_iter;

   assign last_iter = (cnt == CNT_W'(N - 1));

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (x_vld) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            // A request in the result cycle is legal and starts immediately.
            if (x_vld) begin
               accept     = 1'b1;
               state_next = CALC;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   isqrt_step #(.N(N)) u_step (
      .rem       (rem),
      .root      (root),
      .digit     (xs[2*N-1:2*N-2]),
      .rem_next  (rem_next),
      .root_next (root_next)
   );

   // NOTE: the datapath registers are reset too, so x never leaves X in state
   // and reset aborts cleanly; x is only sampled on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         xs   <= '0;
         rem  <= '0;
         root <= '0;
         cnt  <= '0;
         y    <= '0;
         err  <= 1'b0;
      end else begin
         if (accept) begin
            xs   <= x;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
         end else if (state == CALC) begin
            xs   <= xs << 2;
            rem  <= rem_next;
            root <= root_next;
            cnt  <= cnt + 1'b1;
            if (last_iter) y <= root_next;
         end
         // Requests while busy are dropped; the flag is sticky until reset.
         if (x_vld && state == CALC) err <= 1'b1;
      end
   end

   assign y_vld = (state == DONE);
   assign busy  = (state == CALC);

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Scoreboard bench for isqrt_iter_fsm: expected roots and due cycles are queued
// at issue time and checked when y_vld appears.
module tb_isqrt_iter_fsm;

   localparam int N   = 16;
   localparam int LAT = N + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           x_vld;
   logic [2*N-1:0] x;
   logic           y_vld;
   logic [N-1:0]   y;
   logic           busy;
   logic           err;

   typedef struct {
      logic [N-1:0] y;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_t = -1000;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   isqrt_iter_fsm #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y),
      .busy  (busy),
      .err   (err)
   );

   function automatic logic [N-1:0] ref_isqrt(input logic [2*N-1:0] v);
      longint vv = longint'(v);
      longint r  = longint'($sqrt(real'(v)));
      while (r * r > vv) r--;
      while ((r + 1) * (r + 1) <= vv) r++;
      return r[N-1:0];
   endfunction

   // Output monitor: every y_vld must match the oldest expectation, on time.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst !== 1'b1 && y_vld === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_y_vld: cycle %0d y=%0h, none expected", cyc, y);
         end else begin
            e = sb.pop_front();
            if (y !== e.y) begin
               errors++;
               $display("FAIL result: cycle %0d got y=%0h expected %0h", cyc, y, e.y);
            end
            checks++;
            if (cyc != e.due) begin
               errors++;
               $display("FAIL latency: y_vld at cycle %0d expected cycle %0d", cyc, e.due);
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2*N-1:0] v, input bit legal);
      x_vld = 1'b1;
      x     = v;
      if (legal) begin
         sb.push_back('{ref_isqrt(v), cyc + LAT});
         last_t = cyc;
      end
      tick();
      x_vld = 1'b0;
      x     = 'x;
   endtask

   // gap 0 issues in the previous result's DONE cycle; gap>0 leaves idle cycles.
   task automatic issue_after(input logic [2*N-1:0] v, input int gap);
      while (cyc < last_t + LAT + gap) tick();
      issue(v, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      x_vld = 1'b0;
      x     = 'x;
      repeat (3) tick();
      checks += 4;
      if (y_vld !== 1'b0) begin errors++; $display("FAIL reset_y_vld: got %b expected 0", y_vld); end
      if (y !== '0)       begin errors++; $display("FAIL reset_y: got %0h expected 0", y); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [2*N-1:0] vals [7];
      vals = '{32'd0, 32'd1, 32'd99, 32'd100,
               32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
      foreach (vals[i]) begin
         issue_after(vals[i], 2);
         drain();
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      logic exp_busy;
      logic [2*N-1:0] v;
      t0 = cyc;
      for (int k = 0; k <= 52; k++) begin
         exp_busy = (k > 0 && k <= 51 && k != 17 && k != 34 && k != 51);
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL b2b_busy: cycle +%0d got %b expected %b", k, busy, exp_busy);
         end
         if (k == 0 || k == 17 || k == 34) begin
            v = (k == 0) ? 32'd16 : (k == 17) ? 32'd25 : 32'd36;
            x_vld = 1'b1;
            x     = v;
            sb.push_back('{ref_isqrt(v), cyc + LAT});
            last_t = cyc;
         end else begin
            x_vld = 1'b0;
            x     = 'x;
         end
         tick();
      end
      x_vld = 1'b0;
      drain();
   endtask

   task automatic test_protocol();
      int t;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", err); end
      issue_after(32'd1000000, 2);
      t = last_t;
      while (cyc < t + 5) tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", err); end
      issue(32'd4, 1'b0);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_rise: got %b expected 1", err); end
      drain();
      repeat (20) tick();
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
   endtask

   task automatic test_reset_mid();
      int t;
      issue_after(32'd1000000, 2);
      t = last_t;
      while (cyc < t + 8) tick();
      rst = 1'b1;
      sb.delete();
      tick();
      checks += 4;
      if (y_vld !== 1'b0) begin errors++; $display("FAIL midrst_y_vld: got %b expected 0", y_vld); end
      if (y !== '0)       begin errors++; $display("FAIL midrst_y: got %0h expected 0", y); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      if (err !== 1'b0)   begin errors++; $display("FAIL midrst_err: got %b expected 0", err); end
      rst = 1'b0;
      issue(32'd49, 1'b1);
      drain();
   endtask

   task automatic test_random();
      logic [2*N-1:0] v;
      int mode;
      int gap;
      for (int i = 0; i < 2500; i++) begin
         mode = $urandom_range(0, 9);
         if (mode == 0)      v = $urandom_range(0, 300);
         else if (mode == 1) v = 32'hFFFF_FFFF - $urandom_range(0, 70000);
         else                v = $urandom;
         gap = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
         issue_after(v, gap);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_protocol();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
